// File: rtl/load_store_queue.sv
// In-order load/store queue: circular buffer of memory ops filled by the AGU and
// issued to data memory only from the head, loads via a two-state head FSM.
module load_store_queue #(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      disp_valid,
  input  logic                      disp_is_store,
  input  logic                      disp_size,
  input  logic [31:0]               disp_pc,
  input  logic [5:0]                disp_dest_p,
  input  logic                      agu_valid,
  input  logic [31:0]               agu_pc,
  input  logic [31:0]               agu_addr,
  input  logic [31:0]               agu_store_data,
  input  logic                      rob_store_commit,
  input  logic [31:0]               rob_store_pc,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      mem_size,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic [31:0]               mem_rdata,
  output logic                      ld_cmp_valid,
  output logic [31:0]               ld_cmp_pc,
  output logic [5:0]                ld_cmp_dest_p,
  output logic [31:0]               ld_cmp_data,
  output logic                      st_cmp_valid,
  output logic [31:0]               st_cmp_pc,
  output logic                      lsq_full,
  output logic                      dbg_state,
  output logic [$clog2(DEPTH):0]    dbg_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic {IDLE, LOAD_RESP} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     head, tail;
  logic [CNT_W-1:0]  count;

  logic [DEPTH-1:0]  e_valid, e_store, e_size, e_av;
  logic [31:0]       e_pc   [DEPTH];
  logic [5:0]        e_dest [DEPTH];
  logic [31:0]       e_addr [DEPTH];
  logic [31:0]       e_data [DEPTH];

  logic              push, pop, ld_fire;
  logic              fill_hit, fill_en;
  logic [AW-1:0]     fill_idx;
  logic              head_load_rdy, head_store_go;
  logic [7:0]        ld_byte;
  logic [31:0]       ld_data;

  // Dispatch handshake: disp_valid is the offer, !lsq_full the ready; an offer
  // made while the registered count is DEPTH is dropped, not held.
  assign lsq_full  = rstn && (count == CNT_W'(DEPTH));
  assign push      = disp_valid && (count != CNT_W'(DEPTH));
  assign dbg_state = (state == LOAD_RESP);
  assign dbg_count = count;

  // Only already-valid entries can match, so a same-cycle dispatch is never filled.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fill_hit && e_valid[i] && (e_pc[i] == agu_pc)) begin
        fill_hit = 1'b1;
        fill_idx = AW'(i);
      end
    end
  end
  assign fill_en = agu_valid && fill_hit;

  assign head_load_rdy = e_valid[head] && !e_store[head] && e_av[head];
  assign head_store_go = e_valid[head] && e_store[head] && e_av[head] &&
                         rob_store_commit && (rob_store_pc == e_pc[head]);

  always_comb begin
    case (e_addr[head][1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_data = e_size[head] ? mem_rdata : {{24{ld_byte[7]}}, ld_byte};
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    ld_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (head_load_rdy) begin
          mem_req   = 1'b1;
          mem_addr  = e_addr[head];
          mem_size  = e_size[head];
          state_nxt = LOAD_RESP;
        end else if (head_store_go) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = e_addr[head];
          mem_wdata = e_data[head];
          mem_size  = e_size[head];
          pop       = 1'b1;
        end
      end
      LOAD_RESP: begin
        pop       = 1'b1;
        ld_fire   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rstn) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_size  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      e_valid       <= '0;
      ld_cmp_valid  <= 1'b0;
      ld_cmp_pc     <= '0;
      ld_cmp_dest_p <= '0;
      ld_cmp_data   <= '0;
      st_cmp_valid  <= 1'b0;
      st_cmp_pc     <= '0;
    end else begin
      state        <= state_nxt;
      ld_cmp_valid <= ld_fire;
      if (ld_fire) begin
        ld_cmp_pc     <= e_pc[head];
        ld_cmp_dest_p <= e_dest[head];
        ld_cmp_data   <= ld_data;
      end
      st_cmp_valid <= fill_en && e_store[fill_idx];
      if (fill_en && e_store[fill_idx]) st_cmp_pc <= agu_pc;
      if (push) begin
        e_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload needs no reset: it is only observed behind e_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      e_store[tail] <= disp_is_store;
      e_size[tail]  <= disp_size;
      e_pc[tail]    <= disp_pc;
      e_dest[tail]  <= disp_dest_p;
      e_av[tail]    <= 1'b0;
    end
    if (fill_en) begin
      e_av[fill_idx]   <= 1'b1;
      e_addr[fill_idx] <= agu_addr;
      e_data[fill_idx] <= agu_store_data;
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Bench for load_store_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the LSQ's program-order behaviour.
module tb_load_store_queue;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        disp_valid, disp_is_store, disp_size;
  logic [31:0] disp_pc;
  logic [5:0]  disp_dest_p;
  logic        agu_valid;
  logic [31:0] agu_pc, agu_addr, agu_store_data;
  logic        rob_store_commit;
  logic [31:0] rob_store_pc;
  logic        mem_req, mem_we, mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ld_cmp_valid;
  logic [31:0] ld_cmp_pc, ld_cmp_data;
  logic [5:0]  ld_cmp_dest_p;
  logic        st_cmp_valid;
  logic [31:0] st_cmp_pc;
  logic        lsq_full, dbg_state;
  logic [3:0]  dbg_count;

  always #5 clk = ~clk;

  load_store_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_size(disp_size),
    .disp_pc(disp_pc), .disp_dest_p(disp_dest_p),
    .agu_valid(agu_valid), .agu_pc(agu_pc), .agu_addr(agu_addr),
    .agu_store_data(agu_store_data),
    .rob_store_commit(rob_store_commit), .rob_store_pc(rob_store_pc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ld_cmp_valid(ld_cmp_valid), .ld_cmp_pc(ld_cmp_pc), .ld_cmp_dest_p(ld_cmp_dest_p),
    .ld_cmp_data(ld_cmp_data), .st_cmp_valid(st_cmp_valid), .st_cmp_pc(st_cmp_pc),
    .lsq_full(lsq_full), .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  typedef struct {
    logic        st;
    logic        sz;
    logic [31:0] pc;
    logic [5:0]  dest;
    logic        av;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] exp_q[$];
  bit          armed = 1'b0;
  bit          m_busy = 1'b0;
  logic        e_ldv = 1'b0, e_stv = 1'b0;
  logic [31:0] e_ldpc, e_stpc;
  logic [5:0]  e_lddest;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] next_pc = 32'h1000;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_value(logic sz, logic [31:0] a, logic [31:0] rd);
    logic [7:0] b;
    if (sz) return rd;
    b = 8'(rd >> (8 * a[1:0]));
    return {{24{b[7]}}, b};
  endfunction

  task automatic model_check();
    logic        xr, xw, xs;
    logic [31:0] xa, xd;
    xr = 0; xw = 0; xs = 0; xa = 0; xd = 0;
    if (rstn && !m_busy && mq.size() > 0 && mq[0].av) begin
      if (!mq[0].st) begin
        xr = 1; xa = mq[0].addr; xs = mq[0].sz;
      end else if (rob_store_commit && rob_store_pc == mq[0].pc) begin
        xr = 1; xw = 1; xa = mq[0].addr; xd = mq[0].data; xs = mq[0].sz;
      end
    end
    chk("mem_req", mem_req, xr);
    chk("mem_we", mem_we, xw);
    chk("mem_size", mem_size, xs);
    chk("mem_addr", mem_addr, xa);
    chk("mem_wdata", mem_wdata, xd);
    chk("lsq_full", lsq_full, rstn && mq.size() == DEPTH);
    chk("count", dbg_count, mq.size());
    chk("ld_cmp_valid", ld_cmp_valid, e_ldv);
    if (e_ldv) begin
      chk("ld_cmp_pc", ld_cmp_pc, e_ldpc);
      chk("ld_cmp_dest_p", ld_cmp_dest_p, e_lddest);
      if (exp_q.size() == 0) chk("ld_exp_q_empty", 1, 0);
      else chk("ld_cmp_data", ld_cmp_data, exp_q.pop_front());
    end
    chk("st_cmp_valid", st_cmp_valid, e_stv);
    if (e_stv) chk("st_cmp_pc", st_cmp_pc, e_stpc);
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_update();
    bit   do_pop, found, accept;
    ent_t n;
    if (!rstn) begin
      mq.delete(); exp_q.delete();
      m_busy = 0; e_ldv = 0; e_stv = 0; armed = 1;
      return;
    end
    do_pop = 0; e_ldv = 0; e_stv = 0;
    if (m_busy) begin
      e_ldv = 1; e_ldpc = mq[0].pc; e_lddest = mq[0].dest;
      exp_q.push_back(load_value(mq[0].sz, mq[0].addr, mem_rdata));
      do_pop = 1; m_busy = 0;
    end else if (mq.size() > 0 && mq[0].av) begin
      if (!mq[0].st) m_busy = 1;
      else if (rob_store_commit && rob_store_pc == mq[0].pc) do_pop = 1;
    end
    found = 0;
    if (agu_valid) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!found && mq[i].pc == agu_pc) begin
          found = 1;
          mq[i].av = 1; mq[i].addr = agu_addr; mq[i].data = agu_store_data;
          if (mq[i].st) begin e_stv = 1; e_stpc = agu_pc; end
        end
      end
    end
    accept = disp_valid && (mq.size() < DEPTH);
    if (do_pop) void'(mq.pop_front());
    if (accept) begin
      n.st = disp_is_store; n.sz = disp_size; n.pc = disp_pc; n.dest = disp_dest_p;
      n.av = 0; n.addr = 0; n.data = 0;
      mq.push_back(n);
    end
  endtask

  task automatic settle();
    #1;
    if (armed) model_check();
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    rstn = 1; disp_valid = 0; disp_is_store = 0; disp_size = 0; disp_pc = 0; disp_dest_p = 0;
    agu_valid = 0; agu_pc = 0; agu_addr = 0; agu_store_data = 0;
    rob_store_commit = 0; rob_store_pc = 0; mem_rdata = $urandom();
  endtask

  task automatic disp(logic st, logic sz, logic [31:0] pc, logic [5:0] d);
    disp_valid = 1; disp_is_store = st; disp_size = sz; disp_pc = pc; disp_dest_p = d;
  endtask

  task automatic fill(logic [31:0] pc, logic [31:0] a, logic [31:0] d);
    agu_valid = 1; agu_pc = pc; agu_addr = a; agu_store_data = d;
  endtask

  task automatic commit(logic [31:0] pc);
    rob_store_commit = 1; rob_store_pc = pc;
  endtask

  task automatic do_reset();
    idle_inputs(); rstn = 0; tick();
  endtask

  initial begin
    int unf[$];
    chk("model_byte3", load_value(1'b0, 32'h43, 32'h80112233), 32'hFFFFFF80);
    chk("model_byte1", load_value(1'b0, 32'h41, 32'h80112233), 32'h00000022);

    idle_inputs(); rstn = 0; tick();
    idle_inputs(); rstn = 0; tick();
    idle_inputs(); settle();
    chk("rst_ld_pc", ld_cmp_pc, 0); chk("rst_ld_data", ld_cmp_data, 0);
    chk("rst_ld_dest", ld_cmp_dest_p, 0); chk("rst_st_pc", st_cmp_pc, 0);
    chk("rst_state", dbg_state, 0); chk("rst_count", dbg_count, 0);
    advance();

    // Word load
    idle_inputs(); disp(0, 1, 32'h10, 6'd5); tick();
    idle_inputs(); fill(32'h10, 32'h40, 0); tick();
    idle_inputs(); settle();
    chk("wl_req", mem_req, 1); chk("wl_we", mem_we, 0); chk("wl_addr", mem_addr, 32'h40);
    advance();
    idle_inputs(); settle(); chk("wl_req_pulse", mem_req, 0); mem_rdata = 32'hDEADBEEF; advance();
    idle_inputs(); settle();
    chk("wl_valid", ld_cmp_valid, 1); chk("wl_pc", ld_cmp_pc, 32'h10);
    chk("wl_dest", ld_cmp_dest_p, 5); chk("wl_data", ld_cmp_data, 32'hDEADBEEF);
    advance();

    // Byte load, top byte of the word
    idle_inputs(); disp(0, 0, 32'h14, 6'd6); tick();
    idle_inputs(); fill(32'h14, 32'h43, 0); tick();
    idle_inputs(); settle(); chk("bl_req", mem_req, 1); chk("bl_size", mem_size, 0); advance();
    idle_inputs(); mem_rdata = 32'h80112233; tick();
    idle_inputs(); settle(); chk("bl_valid", ld_cmp_valid, 1); chk("bl_data", ld_cmp_data, 32'hFFFFFF80);
    advance();

    // Store with a mismatched then matching commit
    idle_inputs(); disp(1, 1, 32'h20, 0); tick();
    idle_inputs(); fill(32'h20, 32'h80, 32'h55); tick();
    idle_inputs(); commit(32'h24); settle();
    chk("st_cmp_valid", st_cmp_valid, 1); chk("st_cmp_pc", st_cmp_pc, 32'h20);
    chk("st_bad_commit", mem_req, 0);
    advance();
    idle_inputs(); commit(32'h20); settle();
    chk("st_cmp_pulse", st_cmp_valid, 0); chk("st_req", mem_req, 1); chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h80); chk("st_wdata", mem_wdata, 32'h55);
    advance();
    idle_inputs(); settle(); chk("st_popped", dbg_count, 0); advance();

    // Filled load stuck behind an unfilled store; same-cycle dispatch+fill ignored
    idle_inputs(); disp(1, 1, 32'h30, 0); tick();
    idle_inputs(); disp(0, 1, 32'h34, 6'd7); tick();
    idle_inputs(); fill(32'h34, 32'h100, 0); tick();
    idle_inputs(); disp(0, 1, 32'h3C, 6'd9); fill(32'h3C, 32'h200, 0); tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); settle(); chk("order_block", mem_req, 0); advance();
    end
    idle_inputs(); fill(32'h30, 32'h104, 32'h99); tick();
    idle_inputs(); commit(32'h30); settle();
    chk("order_st_we", mem_we, 1); chk("order_st_addr", mem_addr, 32'h104); advance();
    idle_inputs(); settle();
    chk("order_ld_req", mem_req, 1); chk("order_ld_we", mem_we, 0); chk("order_ld_addr", mem_addr, 32'h100);
    advance();
    idle_inputs(); tick();
    idle_inputs(); settle(); chk("order_ld_pc", ld_cmp_pc, 32'h34); advance();
    idle_inputs(); settle(); chk("samecyc_fill_ignored", mem_req, 0); chk("samecyc_count", dbg_count, 1); advance();
    do_reset();

    // Fill to DEPTH, drop extra dispatches, pop one, wrap tail
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs(); disp(0, 1, 32'h200 + 32'(4 * i), 6'(i)); tick();
    end
    idle_inputs(); disp(0, 1, 32'h300, 0); settle(); chk("full_flag", lsq_full, 1); advance();
    idle_inputs(); fill(32'h200, 32'h0, 0); settle(); chk("full_drop", dbg_count, DEPTH); advance();
    idle_inputs(); settle(); chk("full_req", mem_req, 1); advance();
    idle_inputs(); disp(0, 1, 32'h304, 1); tick();
    idle_inputs(); disp(0, 1, 32'h308, 2); settle();
    chk("pop_not_full", lsq_full, 0); chk("pop_count", dbg_count, DEPTH - 1); advance();
    idle_inputs(); settle(); chk("wrap_full", lsq_full, 1); chk("wrap_count", dbg_count, DEPTH); advance();
    do_reset();

    // Reset while waiting for load data
    idle_inputs(); disp(0, 1, 32'h40, 6'd9); tick();
    idle_inputs(); fill(32'h40, 32'h44, 0); tick();
    idle_inputs(); settle(); chk("rr_req", mem_req, 1); advance();
    idle_inputs(); rstn = 0; settle(); chk("rr_in_resp", dbg_state, 1); advance();
    idle_inputs(); settle();
    chk("rr_no_ld", ld_cmp_valid, 0); chk("rr_count", dbg_count, 0);
    chk("rr_full", lsq_full, 0); chk("rr_state", dbg_state, 0);
    advance();
    for (int i = 0; i < 3; i++) begin idle_inputs(); tick(); end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 499) == 0) rstn = 0;
      if ($urandom_range(0, 1) == 1) begin
        disp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), next_pc, 6'($urandom_range(0, 63)));
        next_pc += 4;
      end
      unf.delete();
      for (int i = 0; i < mq.size(); i++) if (!mq[i].av) unf.push_back(i);
      if ($urandom_range(0, 9) < 6) begin
        if (unf.size() > 0) fill(mq[unf[$urandom_range(0, unf.size() - 1)]].pc, $urandom(), $urandom());
        else fill(32'hF000_0000 | 32'($urandom_range(0, 255)), $urandom(), $urandom());
      end
      if (mq.size() > 0 && mq[0].st && mq[0].av && $urandom_range(0, 1) == 1) commit(mq[0].pc);
      else if (mq.size() > 0 && $urandom_range(0, 9) == 0) commit(mq[$urandom_range(0, mq.size() - 1)].pc);
      else if ($urandom_range(0, 9) == 0) commit(32'hE000_0000 | 32'($urandom_range(0, 255)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; synchronous and active-low.
REQ-004 SHALL have dispatch ports disp_valid 1, disp_is_store 1, disp_size 1 (1=word, 0=byte), disp_pc 32, disp_dest_p 6, all inputs.
REQ-005 SHALL have address-fill ports agu_valid 1, agu_pc 32, agu_addr 32, agu_store_data 32, all inputs, sourced from the ALU2 result path.
REQ-006 SHALL have store-commit ports rob_store_commit 1 and rob_store_pc 32, both inputs, sourced from the ROB at store retirement.
REQ-007 SHALL have data-memory ports mem_req 1 out, mem_we 1 out, mem_size 1 out, mem_addr 32 out, mem_wdata 32 out, and mem_rdata 32 in.
REQ-008 SHALL have load-complete outputs ld_cmp_valid 1, ld_cmp_pc 32, ld_cmp_dest_p 6, ld_cmp_data 32, driving ROB complete port 3.
REQ-009 SHALL have store-complete outputs st_cmp_valid 1 and st_cmp_pc 32.
REQ-010 SHALL have output lsq_full 1, a stall to dispatch.

Function
REQ-011 SHALL implement a circular buffer with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
REQ-012 SHALL store per entry: valid, is_store, size, pc, dest_p, addr_valid, addr, data.
REQ-013 SHALL, on disp_valid with count<DEPTH, write the tail entry with addr_valid=0 and advance tail.
REQ-014 SHALL drop dispatch when registered count==DEPTH, even if a pop occurs in the same cycle.
REQ-015 SHALL assert lsq_full combinationally whenever count==DEPTH.
REQ-016 SHALL, on agu_valid, fill addr/data and set addr_valid in the unique valid entry whose pc==agu_pc; if no entry matches (including an entry dispatched in the same cycle), SHALL ignore the fill.
REQ-017 SHALL, when agu fills a store entry, assert st_cmp_valid and st_cmp_pc=agu_pc for exactly the following cycle.
REQ-018 SHALL run a head FSM with states IDLE and LOAD_RESP, and SHALL access memory only from the head, in program order, with no forwarding or bypass.
REQ-019 SHALL, in IDLE, when the head is a valid load with addr_valid: drive mem_req=1, mem_we=0, mem_addr=addr, mem_size=size for one cycle, then go to LOAD_RESP.
REQ-020 SHALL, in LOAD_RESP: sample mem_rdata; register ld_cmp_valid=1, ld_cmp_pc, ld_cmp_dest_p, ld_cmp_data (visible next cycle, one-cycle pulse); pop the head; return to IDLE.
REQ-021 SHALL, for byte loads, set ld_cmp_data to the sign-extended byte of mem_rdata selected by addr[1:0] (0 = bits 7:0); word loads pass mem_rdata unchanged.
REQ-022 SHALL, in IDLE, when the head is a valid store with addr_valid, rob_store_commit=1 and rob_store_pc==head pc: drive mem_req=1, mem_we=1, mem_addr, mem_wdata=data, mem_size; pop the head in the same cycle; stay in IDLE.
REQ-023 SHALL ignore rob_store_commit when it does not match a ready store at the head.
REQ-024 SHALL leave the head blocked in IDLE while its address is not yet filled.
REQ-025 SHALL, on simultaneous dispatch and pop, update count by zero.
REQ-026 SHALL drive mem_req low, and all other mem_* outputs to zero, in every cycle without a request.

Reset
REQ-027 SHALL, while rstn=0 at a clock edge, clear all valid bits, pointers and count, set the FSM to IDLE, and force lsq_full, mem_req, mem_we, ld_cmp_valid and st_cmp_valid to 0 with all data outputs at 0.
REQ-028 SHALL, on reset asserted during LOAD_RESP, discard the in-flight load so that no ld_cmp_valid is produced afterwards.

Verification
REQ-029 SHALL cover: dispatch load pc=0x10, dest_p=5, word; agu addr=0x40; mem_rdata=0xDEADBEEF -> mem_req pulse with addr 0x40, then ld_cmp_valid with pc 0x10, dest_p 5, data 0xDEADBEEF.
REQ-030 SHALL cover: byte load addr=0x43, mem_rdata=0x80112233 -> ld_cmp_data=0xFFFFFF80.
REQ-031 SHALL cover: store pc=0x20 filled with addr 0x80, data 0x55; commit pc=0x24 then pc=0x20 -> no write on 0x24; write to addr 0x80 with data 0x55 on 0x20; st_cmp_valid one cycle after the fill.
REQ-032 SHALL cover: 8 dispatches then a 9th -> lsq_full=1 and the 9th is dropped; after one pop, a new dispatch is accepted and tail wraps to 0.
REQ-033 SHALL cover: a younger load with its address filled behind an unfilled older store -> no mem_req until the store commits.
REQ-034 SHALL cover: rstn=0 during LOAD_RESP -> no ld_cmp_valid, count=0, lsq_full=0.
